// File: rtl/ssd_scan_display.sv
// ssd_scan_display: time-multiplexed seven-segment scanner fed by a press-loaded digit ring buffer.
// Define SSD_LOAD_DEBOUNCE_EN to debounce the load button before edge detection.
module ssd_scan_display #(
  parameter int DIGITS          = 4,
  parameter int REFRESH_DIV     = 50000,
  parameter int DEBOUNCE_CYCLES = 65536
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              clear,
  input  logic [3:0]        user_inp,
  output logic [DIGITS-1:0] active_digit,
  output logic [6:0]        seven_out,
  output logic [DIGITS-1:0] digits_valid
);
  localparam int PW = $clog2(DIGITS);
  localparam int RW = $clog2(REFRESH_DIV);

  if (DIGITS < 2 || DIGITS > 8 || REFRESH_DIV < 2 || DEBOUNCE_CYCLES < 2) begin : g_bad_params
    $error("ssd_scan_display: parameter out of range");
  end

  logic [1:0]              sync_q, fill_q;
  logic                    prev_q, armed_q, lvl, press;
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d, scan_q, scan_d;
  logic [DIGITS-1:0]       valid_q, valid_d, an_q, an_d;
  logic [DIGITS-1:0][3:0]  dig_q, dig_d;
  logic [RW-1:0]           ref_q, ref_d;
  logic                    ref_tc;
  logic [6:0]              seg_q, seg_d;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  // fill_q marks when the synchroniser holds real samples; a press is armed only
  // after load has genuinely been seen low, so a button held through reset is ignored
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q  <= '0;
      fill_q  <= '0;
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], load};
      fill_q  <= {fill_q[0], 1'b1};
      prev_q  <= lvl;
      armed_q <= armed_q | (fill_q[1] & ~sync_q[1]);
    end
  end

`ifdef SSD_LOAD_DEBOUNCE_EN
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  logic [DW-1:0] db_cnt_q, db_cnt_d;
  logic          db_lvl_q, db_lvl_d;

  always_comb begin
    db_cnt_d = '0;
    db_lvl_d = db_lvl_q;
    if (sync_q[1] != db_lvl_q) begin
      if (db_cnt_q == DW'(DEBOUNCE_CYCLES - 1)) db_lvl_d = sync_q[1];
      else db_cnt_d = db_cnt_q + DW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      db_cnt_q <= '0;
      db_lvl_q <= 1'b0;
    end else begin
      db_cnt_q <= db_cnt_d;
      db_lvl_q <= db_lvl_d;
    end
  end

  assign lvl = db_lvl_q;
`else
  assign lvl = sync_q[1];
`endif

  assign press = lvl & ~prev_q & armed_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    valid_d  = valid_q;
    dig_d    = dig_q;
    if (clear) begin
      valid_d  = '0;
      wr_ptr_d = '0;
    end else if (press) begin
      dig_d[wr_ptr_q]   = user_inp;
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d          = (wr_ptr_q == PW'(DIGITS - 1)) ? '0 : wr_ptr_q + PW'(1);
    end
  end

  always_comb begin
    ref_tc = ref_q == RW'(REFRESH_DIV - 1);
    ref_d  = ref_tc ? '0 : ref_q + RW'(1);
    scan_d = !ref_tc ? scan_q : (scan_q == PW'(DIGITS - 1)) ? '0 : scan_q + PW'(1);
    an_d   = ~(DIGITS'(1) << scan_q);
    seg_d  = valid_q[scan_q] ? hex7(dig_q[scan_q]) : 7'b1111111;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      valid_q  <= '0;
      dig_q    <= '0;
      ref_q    <= '0;
      scan_q   <= '0;
      an_q     <= '1;
      seg_q    <= '1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      valid_q  <= valid_d;
      dig_q    <= dig_d;
      ref_q    <= ref_d;
      scan_q   <= scan_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
    end
  end

  assign active_digit = an_q;
  assign seven_out    = seg_q;
  assign digits_valid = valid_q;
endmodule

// File: tb/tb_ssd_scan_display.sv
// tb_ssd_scan_display: directed and random presses/clears checked against an array model of the display.
module tb_ssd_scan_display;
  localparam int D = 4, R = 4, B = 3;

  logic clk = 0, reset = 0, load = 0, clear = 0;
  logic [3:0] user_inp = '0;
  logic [D-1:0] active_digit, digits_valid;
  logic [6:0] seven_out;

  ssd_scan_display #(.DIGITS(D), .REFRESH_DIV(R), .DEBOUNCE_CYCLES(B)) dut (
    .clk(clk), .reset(reset), .load(load), .clear(clear), .user_inp(user_inp),
    .active_digit(active_digit), .seven_out(seven_out), .digits_valid(digits_valid)
  );

  always #5 clk = ~clk;

  int cmp = 0, mis = 0;
  logic [3:0] mdig [D];
  bit mval [D];
  int mptr = 0;
  logic [6:0] seg_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp++;
    assert (obs === exp) else begin
      mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [D-1:0] mvalid();
    logic [D-1:0] v;
    for (int i = 0; i < D; i++) v[i] = mval[i];
    return v;
  endfunction

  task automatic mclear();
    for (int i = 0; i < D; i++) mval[i] = 0;
    mptr = 0;
  endtask

  task automatic mwrite(input logic [3:0] v);
    mdig[mptr] = v;
    mval[mptr] = 1;
    mptr = (mptr + 1) % D;
  endtask

  task automatic press(input logic [3:0] v);
    user_inp = v;
    load = 1;
    tick(6);
    load = 0;
    tick(6);
    mwrite(v);
  endtask

  task automatic clear_pulse();
    clear = 1;
    tick(1);
    clear = 0;
    tick(1);
    mclear();
  endtask

  task automatic check_display(input string tag);
    for (int c = 0; c < 2 * D * R; c++) begin
      int idx = 0, zeros = 0;
      for (int i = 0; i < D; i++) if (active_digit[i] === 1'b0) begin idx = i; zeros++; end
      chk({tag, "_onecold"}, zeros, 1);
      chk({tag, "_seg"}, seven_out, mval[idx] ? seg_tab[mdig[idx]] : 7'b1111111);
      tick(1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [D-1:0] exp_an;
    int n;
    mclear();
    for (int i = 0; i < D; i++) mdig[i] = '0;
    tick(5);
    chk("rst_an", active_digit, 4'b1111);
    chk("rst_seg", seven_out, 7'b1111111);
    chk("rst_valid", digits_valid, 4'b0000);
    reset = 1;
    for (int k = 1; k <= 4 * R; k++) begin
      @(negedge clk);
      exp_an = ~(4'(1) << (((k - 1) / R) % D));
      chk("scan_an", active_digit, exp_an);
      chk("scan_blank", seven_out, 7'b1111111);
    end

    press(4'h1);
    press(4'h8);
    chk("load_valid", digits_valid, 4'b0011);
    check_display("load");

    clear_pulse();
    chk("clr_valid", digits_valid, 4'b0000);
    press(4'hA); press(4'h1); press(4'h2); press(4'h3); press(4'hF);
    chk("wrap_valid", digits_valid, 4'b1111);
    chk("wrap_ptr", dut.wr_ptr_q, 1);
    check_display("wrap");

    clear = 1;
    user_inp = 4'h5;
    load = 1;
    tick(6);
    load = 0;
    tick(6);
    clear = 0;
    tick(2);
    mclear();
    chk("clrpress_valid", digits_valid, 4'b0000);
    check_display("clrpress");

    user_inp = 4'h6;
    load = 1;
    tick(2);
    load = 0;
    tick(10);
`ifndef SSD_LOAD_DEBOUNCE_EN
    mwrite(4'h6);
`endif
    chk("glitch_valid", digits_valid, mvalid());
    press(4'hC);
    chk("long_valid", digits_valid, mvalid());
    check_display("long");

    for (int it = 0; it < 24; it++) begin
      if ($urandom_range(4) == 0) clear_pulse();
      else press(4'($urandom_range(15)));
      chk("rnd_valid", digits_valid, mvalid());
      if (it % 4 == 3) check_display("rnd");
    end

    load = 1;
    reset = 0;
    tick(3);
    reset = 1;
    tick(12);
    mclear();
    chk("held_valid", digits_valid, 4'b0000);
    load = 0;
    tick(8);
    chk("held_low_valid", digits_valid, 4'b0000);
    press(4'h7);
    chk("held_press_valid", digits_valid, 4'b0001);
    check_display("held");

    n = 0;
    while (active_digit !== 4'b1011 && n < 64) begin
      tick(1);
      n++;
    end
    chk("find_digit2", n < 64, 1);
    reset = 0;
    #1;
    chk("midscan_an", active_digit, 4'b1111);
    chk("midscan_seg", seven_out, 7'b1111111);
    chk("midscan_valid", digits_valid, 4'b0000);
    mclear();
    tick(2);
    reset = 1;
    @(negedge clk);
    chk("restart_an", active_digit, 4'b1110);
    check_display("restart");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
    $finish;
  end
endmodule
